// File: rtl/add_sub_pkg.sv
// Shared types and constants for the nibble-serial add/sub controller and its 4-bit slice.
package add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int   NIBBLE_W = 4;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/add_sub_nibble.sv
// Combinational 4-bit add/sub slice with explicit carry-in so nibbles can be chained.
module add_sub_nibble
    import add_sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                m,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] s,
    output logic                c_out,
    output logic                v
);

    logic [NIBBLE_W-1:0] b_x;
    logic [NIBBLE_W:0]   c;

    always_comb begin
        b_x  = b ^ {NIBBLE_W{m}};
        c    = '0;
        s    = '0;
        c[0] = c_in;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]   = a[i] ^ b_x[i] ^ c[i];
            c[i+1] = (a[i] & b_x[i]) | (a[i] & c[i]) | (b_x[i] & c[i]);
        end
        c_out = c[NIBBLE_W];
        // Signed overflow: carry into the MSB disagrees with carry out of it.
        v     = c[NIBBLE_W-1] ^ c[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_add_sub_ctrl.sv
// WIDTH-bit add/sub sequenced one nibble per clock through a shared slice, LSB first.
// start->done latency NIB+1 cycles; start accepted only while ready (IDLE/DONE), never queued in RUN.
module nibble_serial_add_sub_ctrl
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             m,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_w_q, a_w_d;
    logic [WIDTH-1:0]   b_w_q, b_w_d;
    logic               m_w_q, m_w_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
    logic                nib_c, nib_v;
    logic                accept, last;

    assign nib_a  = a_w_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign nib_b  = b_w_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign accept = start && (state_q != ST_RUN);
    assign last   = (state_q == ST_RUN) && (idx_q == IDX_W'(NIB - 1));

    add_sub_nibble u_slice (
        .a     (nib_a),
        .b     (nib_b),
        .m     (m_w_q),
        .c_in  (carry_q),
        .s     (nib_s),
        .c_out (nib_c),
        .v     (nib_v)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        ready = (state_q != ST_RUN);
        busy  = (state_q == ST_RUN);
        done  = (state_q == ST_DONE);
    end

    assign result = result_q;
    assign c_out  = c_out_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

    always_comb begin
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_w_d    = a_w_q;
        b_w_d    = b_w_q;
        m_w_d    = m_w_q;
        sum_d    = sum_q;
        result_d = result_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        if (accept) begin
            // Carry-in of m turns the inverted b into its two's complement.
            a_w_d   = a;
            b_w_d   = b;
            m_w_d   = m;
            carry_d = m;
            idx_d   = '0;
            sum_d   = '0;
        end else if (state_q == ST_RUN) begin
            sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_s;
            carry_d = nib_c;
            idx_d   = idx_q + IDX_W'(1);
            if (last) begin
                idx_d    = '0;
                result_d = sum_d;
                c_out_d  = nib_c;
                ovf_d    = nib_v;
                zero_d   = (sum_d == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_w_q    <= '0;
            b_w_q    <= '0;
            m_w_q    <= 1'b0;
            sum_q    <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_w_q    <= a_w_d;
            b_w_q    <= b_w_d;
            m_w_q    <= m_w_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_sub_ctrl.sv
// Scoreboard bench for nibble_serial_add_sub_ctrl: expected results queued at launch, checked on done.
module tb_nibble_serial_add_sub_ctrl;
    import add_sub_pkg::*;

    localparam int W   = 16;
    localparam int NIB = W / NIBBLE_W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         m = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready, busy, done, c_out, ovf, zero;
    logic [W-1:0] result;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         z;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [W-1:0] last_res = '0;
    int           n_vec = 0;
    int           n_err = 0;
    int           n_done = 0;
    int           n_launch = 0;

    nibble_serial_add_sub_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .m      (m),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .c_out  (c_out),
        .ovf    (ovf),
        .zero   (zero)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic mode);
        logic [W-1:0] yb;
        logic [W:0]   full;
        exp_t         e;
        yb    = mode ? ~y : y;
        full  = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, mode};
        e.res = full[W-1:0];
        e.co  = full[W];
        e.ov  = (x[W-1] == yb[W-1]) && (e.res[W-1] != x[W-1]);
        e.z   = (e.res == '0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'(1), 32'(0));
            end else begin
                mon_e = sb_q.pop_front();
                chk("result", 32'(result), 32'(mon_e.res));
                chk("c_out",  32'(c_out),  32'(mon_e.co));
                chk("ovf",    32'(ovf),    32'(mon_e.ov));
                chk("zero",   32'(zero),   32'(mon_e.z));
                last_res = mon_e.res;
            end
        end
    end

    // Called at a negedge; the following posedge is the accepting edge.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic mode);
        a     = x;
        b     = y;
        m     = mode;
        start = 1'b1;
        sb_q.push_back(model(x, y, mode));
        n_launch++;
    endtask

    // Returns at the negedge of the DONE cycle.
    task automatic wait_done(input bit pulse_mid, input bit toggle);
        int lat;
        lat = 0;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                if (toggle) begin
                    a = ~a;
                    b = W'($urandom);
                    m = ~m;
                end
            end
            if (pulse_mid && k == 2) start = 1'b1;
            if (pulse_mid && k == 3) start = 1'b0;
            chk("busy",  32'(busy),  32'(k <= NIB));
            chk("ready", 32'(ready), 32'(k > NIB));
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(NIB + 1));
    endtask

    initial begin
        int done_before;

        #1;
        chk("rst_ready",  32'(ready),  32'(1));
        chk("rst_busy",   32'(busy),   32'(0));
        chk("rst_done",   32'(done),   32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_flags",  32'({c_out, ovf, zero}), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        launch(16'h1234, 16'h0FCD, MODE_ADD);
        wait_done(1'b0, 1'b0);
        chk("add_2201", 32'(result), 32'h2201);

        @(negedge clk);
        launch(16'h0005, 16'h0007, MODE_SUB);
        wait_done(1'b0, 1'b0);
        chk("sub_fffe", 32'({result, c_out}), 32'({16'hFFFE, 1'b0}));

        @(negedge clk);
        launch(16'hA5A5, 16'hA5A5, MODE_SUB);
        wait_done(1'b0, 1'b0);

        @(negedge clk);
        launch(16'h7FFF, 16'h0001, MODE_ADD);
        wait_done(1'b0, 1'b0);
        chk("ovf_pos", 32'({result, ovf}), 32'({16'h8000, 1'b1}));

        @(negedge clk);
        launch(16'hFFFF, 16'h0001, MODE_ADD);
        wait_done(1'b0, 1'b0);

        @(negedge clk);
        launch(16'h8000, 16'h0001, MODE_SUB);
        wait_done(1'b0, 1'b0);

        // start pulsed mid-RUN must be dropped
        @(negedge clk);
        launch(16'h4321, 16'h1111, MODE_SUB);
        wait_done(1'b1, 1'b0);

        // operands toggled after acceptance
        @(negedge clk);
        launch(16'h1357, 16'h2468, MODE_ADD);
        wait_done(1'b0, 1'b1);

        // back-to-back: next start presented in the DONE cycle
        @(negedge clk);
        launch(16'h00FF, 16'h0F01, MODE_ADD);
        wait_done(1'b0, 1'b0);
        launch(16'h1000, 16'h2000, MODE_SUB);
        wait_done(1'b0, 1'b0);

        repeat (3) begin
            @(negedge clk);
            chk("hold_result", 32'(result), 32'(last_res));
            chk("idle_ready",  32'(ready),  32'(1));
        end

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            launch(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            wait_done(1'b0, 1'b0);
        end

        // reset during idx=2 discards the operation
        @(negedge clk);
        launch(16'h1234, 16'h0FCD, MODE_ADD);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        void'(sb_q.pop_back());
        n_launch--;
        done_before = n_done;
        #1;
        chk("mid_rst_busy",   32'(busy),   32'(0));
        chk("mid_rst_done",   32'(done),   32'(0));
        chk("mid_rst_ready",  32'(ready),  32'(1));
        chk("mid_rst_result", 32'(result), 32'(0));
        chk("mid_rst_flags",  32'({c_out, ovf, zero}), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("no_done_after_rst", 32'(n_done), 32'(done_before));

        launch(16'h0003, 16'h0004, MODE_ADD);
        wait_done(1'b0, 1'b0);
        chk("post_rst_0007", 32'(result), 32'h0007);

        repeat (8) @(negedge clk);
        chk("sb_empty",   32'(sb_q.size()), 32'(0));
        chk("done_count", 32'(n_done),      32'(n_launch));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
